// File: rtl/kws_decision.sv
// Keyword-spotting decision stage: moving-average smoothing, serial argmax, thresholded detection.
// Optional build macro KWS_DECISION_HOLDOFF_EN enables post-detection hold-off suppression.
module kws_decision #(
    parameter int NUM_KEYWORDS   = 10,
    parameter int ACTIV_BITS     = 8,
    parameter int WIN_LEN        = 4,
    parameter int HOLDOFF_FRAMES = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_KEYWORDS*ACTIV_BITS-1:0] scores_in,
    input  logic                            scores_valid,
    input  logic [ACTIV_BITS-1:0]           threshold,
    output logic                            ready,
    output logic                            detect_valid,
    output logic [$clog2(NUM_KEYWORDS)-1:0] detect_id,
    output logic [ACTIV_BITS-1:0]           detect_score,
    output logic                            frame_done,
    output logic                            drop_err
);
    localparam int LOG2W  = $clog2(WIN_LEN);
    localparam int SUM_W  = ACTIV_BITS + LOG2W;
    localparam int ID_W   = $clog2(NUM_KEYWORDS);
    localparam int VEC_W  = NUM_KEYWORDS * ACTIV_BITS;
    localparam int FILL_W = $clog2(WIN_LEN + 1);

    if (WIN_LEN < 2 || WIN_LEN > 16 || (WIN_LEN & (WIN_LEN - 1)) != 0) begin : g_bad_win
        $error("kws_decision: WIN_LEN must be a power of two in 2..16");
    end
    if (HOLDOFF_FRAMES < 0 || HOLDOFF_FRAMES > 255) begin : g_bad_hold
        $error("kws_decision: HOLDOFF_FRAMES must be in 0..255");
    end

    typedef enum logic [1:0] {IDLE, UPDATE, SCAN, DECIDE} state_t;
    state_t state_reg, state_next;

    logic [VEC_W-1:0]      new_reg;
    logic [VEC_W-1:0]      ring_mem [WIN_LEN];
    logic [LOG2W-1:0]      wr_ptr_reg;
    logic [FILL_W-1:0]     fill_cnt_reg;
    logic [SUM_W-1:0]      sum_reg [NUM_KEYWORDS];
    logic [ID_W-1:0]       scan_idx_reg;
    logic [ACTIV_BITS-1:0] best_avg_reg;
    logic [ID_W-1:0]       best_id_reg;
    logic [VEC_W-1:0]      avg_all;
    logic [ACTIV_BITS-1:0] scan_avg;
    logic                  window_full;
    logic                  hold_clear;
    logic                  hit;

    assign ready = (state_reg == IDLE);

    // Averages are the sums with the low log2(WIN_LEN) bits dropped.
    for (genvar gi = 0; gi < NUM_KEYWORDS; gi++) begin : g_avg
        assign avg_all[gi*ACTIV_BITS +: ACTIV_BITS] = sum_reg[gi][SUM_W-1:LOG2W];
    end
    assign scan_avg = avg_all[scan_idx_reg*ACTIV_BITS +: ACTIV_BITS];

    assign window_full = (fill_cnt_reg == FILL_W'(WIN_LEN));
    assign hit         = window_full && (best_avg_reg >= threshold) && hold_clear;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (scores_valid) state_next = UPDATE;
            UPDATE:  state_next = SCAN;
            SCAN:    if (scan_idx_reg == ID_W'(NUM_KEYWORDS - 1)) state_next = DECIDE;
            DECIDE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WIN_LEN; w++) ring_mem[w] <= '0;
        end else if (state_reg == UPDATE) begin
            ring_mem[wr_ptr_reg] <= new_reg;
        end
    end

    // The slot being overwritten holds the oldest vector, already part of the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_KEYWORDS; k++) sum_reg[k] <= '0;
        end else if (state_reg == UPDATE) begin
            for (int k = 0; k < NUM_KEYWORDS; k++) begin
                sum_reg[k] <= sum_reg[k]
                            + SUM_W'(new_reg[k*ACTIV_BITS +: ACTIV_BITS])
                            - SUM_W'(ring_mem[wr_ptr_reg][k*ACTIV_BITS +: ACTIV_BITS]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            new_reg      <= '0;
            wr_ptr_reg   <= '0;
            fill_cnt_reg <= '0;
            scan_idx_reg <= '0;
            best_avg_reg <= '0;
            best_id_reg  <= '0;
            detect_valid <= 1'b0;
            detect_id    <= '0;
            detect_score <= '0;
            frame_done   <= 1'b0;
            drop_err     <= 1'b0;
        end else begin
            detect_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (scores_valid && !ready) drop_err <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (scores_valid) new_reg <= scores_in;
                end
                UPDATE: begin
                    wr_ptr_reg   <= wr_ptr_reg + 1'b1;
                    scan_idx_reg <= '0;
                    if (!window_full) fill_cnt_reg <= fill_cnt_reg + 1'b1;
                end
                SCAN: begin
                    // Strictly-greater replacement keeps the lowest index on ties.
                    if (scan_idx_reg == '0 || scan_avg > best_avg_reg) begin
                        best_avg_reg <= scan_avg;
                        best_id_reg  <= scan_idx_reg;
                    end
                    scan_idx_reg <= scan_idx_reg + 1'b1;
                end
                DECIDE: begin
                    frame_done <= 1'b1;
                    if (hit) begin
                        detect_valid <= 1'b1;
                        detect_id    <= best_id_reg;
                        detect_score <= best_avg_reg;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef KWS_DECISION_HOLDOFF_EN
    logic [7:0] hold_cnt_reg;

    assign hold_clear = (hold_cnt_reg == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_reg <= 8'd0;
        end else if (state_reg == DECIDE) begin
            if (hit)               hold_cnt_reg <= 8'(HOLDOFF_FRAMES);
            else if (!hold_clear)  hold_cnt_reg <= hold_cnt_reg - 8'd1;
        end
    end
`else
    assign hold_clear = 1'b1;
`endif

endmodule

// File: doc/kws_decision.md
# kws_decision

Post-processing stage directly downstream of the keyword-spotting accelerator: consumes per-frame softmax score vectors (`kws_result`/`kws_valid`), smooths each class score with a moving average over `WIN_LEN` frames, selects the best class by serial argmax, and emits a single-cycle detection event when the smoothed score crosses a programmable threshold. Suppresses repeated detections of one utterance with a frame-count hold-off and gates detections until the averaging window is full.

## Interface
- `NUM_KEYWORDS`, 10, number of classes in the score vector
- `ACTIV_BITS`, 8, width of each unsigned class score
- `WIN_LEN`, 4, averaging window in frames; power of two, 2..16
- `HOLDOFF_FRAMES`, 8, frames suppressed after a detection; 0..255

- `clk` in 1 — single clock, all logic rising-edge
- `rst` in 1 — synchronous, active-high reset
- `scores_in` in `NUM_KEYWORDS*ACTIV_BITS` — class k at bits [k*ACTIV_BITS +: ACTIV_BITS], unsigned
- `scores_valid` in 1 — score vector present this cycle
- `threshold` in `ACTIV_BITS` — detection threshold on averaged score; sampled at DECIDE
- `ready` out 1 — high only in IDLE; vector accepted when `scores_valid && ready`
- `detect_valid` out 1 — one-cycle detection pulse
- `detect_id` out `$clog2(NUM_KEYWORDS)` — winning class index, held until next detection
- `detect_score` out `ACTIV_BITS` — averaged score of winner, held until next detection
- `frame_done` out 1 — one-cycle pulse at end of every processed frame
- `drop_err` out 1 — sticky: a vector arrived while `ready` was low

## Operation
- Storage: ring buffer of `WIN_LEN` score vectors, write pointer `wr_ptr` (wraps `WIN_LEN-1` -> 0); per-class running sum, width `ACTIV_BITS + log2(WIN_LEN)`; warm-up counter `fill_cnt` saturating at `WIN_LEN`; hold-off counter `hold_cnt` (8 bits).
- FSM states: IDLE, UPDATE, SCAN, DECIDE.
  - IDLE: on `scores_valid`, register `scores_in` -> UPDATE.
  - UPDATE: all classes in parallel: `sum[k] <= sum[k] + new[k] - buf[wr_ptr][k]`; `buf[wr_ptr] <= new`; `wr_ptr++`; `fill_cnt++` if < `WIN_LEN` -> SCAN, class index 0.
  - SCAN: one class per cycle, `avg[k] = sum[k] >> log2(WIN_LEN)`; best replaced only on strictly greater (ties -> lowest index); after class `NUM_KEYWORDS-1` -> DECIDE.
  - DECIDE: `hit = (fill_cnt == WIN_LEN) && (best_avg >= threshold) && (hold_cnt == 0)`. On hit: latch `detect_id`/`detect_score`, `hold_cnt <= HOLDOFF_FRAMES`. Else if `hold_cnt != 0`: `hold_cnt--`. -> IDLE.
- Running sums never overflow: max `WIN_LEN*(2^ACTIV_BITS-1)` fits exactly; subtraction never underflows (oldest entry already included).
- `scores_valid` while not IDLE: vector dropped, no state change, `drop_err <= 1` (cleared only by `rst`).
- Reset: buffer entries, sums, `wr_ptr`, `fill_cnt`, `hold_cnt`, `drop_err`, `detect_valid`, `frame_done`, `detect_id`, `detect_score` all 0; FSM -> IDLE; `ready` = 1 in first cycle after reset. Reset mid-frame discards the frame with no outputs.

## Timing
- Vector accepted at edge t: UPDATE in cycle t+1, SCAN t+2 .. t+1+`NUM_KEYWORDS`, DECIDE t+2+`NUM_KEYWORDS`, `frame_done` (and `detect_valid` on hit) high in cycle t+3+`NUM_KEYWORDS`; `ready` high again in that same cycle.
- Latency 13 cycles at defaults; max sustained rate one vector per `NUM_KEYWORDS+3` cycles.
- `ready` low from t+1 through t+2+`NUM_KEYWORDS`.
- Warm-up: first possible detection on frame `WIN_LEN`.
- Hold-off: after detection on frame n, frames n+1 .. n+`HOLDOFF_FRAMES` cannot detect; frame n+`HOLDOFF_FRAMES`+1 can.

## Configuration
- `KWS_DECISION_HOLDOFF_EN` defined: hold-off counter and suppression as above.
- Undefined: `hold_cnt` removed, `hit` ignores hold-off; every qualifying frame produces `detect_valid`; `HOLDOFF_FRAMES` unused.

## Test plan
- Reset then four vectors with class 3 = 200, others 10, threshold 128 -> no detection frames 1-3; frame 4 `detect_valid`, `detect_id`=3, `detect_score`=200, 13 cycles after acceptance.
- Continuous class-3 = 200 vectors with hold-off enabled, `HOLDOFF_FRAMES`=8 -> detections on frames 4 and 13 only; macro undefined -> detection every frame from 4.
- Classes 2 and 7 both 180 for four frames -> `detect_id`=2 (tie to lowest index).
- Window slide: four frames class 5 = 255, then four frames all 0 -> averages of class 5 of 255,191,127,63,0 over frames 4-8; with threshold 128 detection only while avg >= 128.
- `scores_valid` asserted 5 cycles after an accepted vector -> dropped, `drop_err`=1 and stays 1, averages unaffected.
- `rst` asserted during SCAN -> no `frame_done`/`detect_valid`, all outputs 0 next cycle, following frame treated as frame 1 of warm-up.
